req_pulse_responder: RTL

REQ_PULSE_RESPONDER -- requirements
Module: req_pulse_responder

---
 rtl/req_pulse_responder.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/req_pulse_responder.sv
// Request/acknowledge pulse responder: fixed-latency ack with incremented payload,
// a one-deep pending slot and sticky protocol-error flags.
// Optional embedded protocol assertions: define REQ_PULSE_RESPONDER_SVA_EN.
module req_pulse_responder #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned LATENCY = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [DATA_W-1:0] req_data,
    output logic              ack,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic              err_b2b,
    output logic              err_ovf,
    output logic [7:0]        err_cnt
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StWait = 2'd1;
    localparam logic [1:0] StAck  = 2'd2;

    localparam logic [3:0] LoadCnt = 4'(LATENCY - 1);

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] cur_q, cur_d;
    logic [DATA_W-1:0] pend_q, pend_d;
    logic              pend_valid_q, pend_valid_d;
    logic [DATA_W-1:0] rsp_q, rsp_d;
    logic              hist_q;
    logic              b2b_q, b2b_d;
    logic              ovf_q, ovf_d;
    logic [7:0]        errcnt_q, errcnt_d;

    logic b2b_hit, ovf_hit, new_req;

    // The pending slot is judged full by its value at the sample edge, even if it drains then.
    assign b2b_hit = req & hist_q;
    assign ovf_hit = req & (state_q != StIdle) & pend_valid_q;
    assign new_req = req & ~b2b_hit & ~ovf_hit;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cur_d        = cur_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        rsp_d        = rsp_q;
        b2b_d        = b2b_q | b2b_hit;
        ovf_d        = ovf_q | ovf_hit;
        errcnt_d     = errcnt_q;
        if ((b2b_hit || ovf_hit) && errcnt_q != 8'hFF) begin
            errcnt_d = errcnt_q + 8'd1;
        end

        case (state_q)
            StIdle: begin
                if (new_req) begin
                    cur_d = req_data;
                    if (LoadCnt == 4'd0) begin
                        state_d = StAck;
                        rsp_d   = req_data + DATA_W'(1);
                    end else begin
                        state_d = StWait;
                        cnt_d   = LoadCnt;
                    end
                end
            end
            StWait: begin
                // A zero count only occurs when a pending request is reloaded with LATENCY=1.
                if (cnt_q <= 4'd1) begin
                    state_d = StAck;
                    cnt_d   = 4'd0;
                    rsp_d   = cur_q + DATA_W'(1);
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
                if (new_req) begin
                    pend_valid_d = 1'b1;
                    pend_d       = req_data;
                end
            end
            StAck: begin
                if (pend_valid_q) begin
                    state_d      = StWait;
                    cnt_d        = LoadCnt;
                    cur_d        = pend_q;
                    pend_valid_d = 1'b0;
                end else begin
                    state_d = StIdle;
                end
                if (new_req) begin
                    pend_valid_d = 1'b1;
                    pend_d       = req_data;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= 4'd0;
            cur_q        <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            rsp_q        <= '0;
            hist_q       <= 1'b0;
            b2b_q        <= 1'b0;
            ovf_q        <= 1'b0;
            errcnt_q     <= 8'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cur_q        <= cur_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            rsp_q        <= rsp_d;
            hist_q       <= req;
            b2b_q        <= b2b_d;
            ovf_q        <= ovf_d;
            errcnt_q     <= errcnt_d;
        end
    end

    assign ack      = (state_q == StAck);
    assign rsp_data = rsp_q;
    assign busy     = (state_q != StIdle) | pend_valid_q;
    assign err_b2b  = b2b_q;
    assign err_ovf  = ovf_q;
    assign err_cnt  = errcnt_q;

`ifdef REQ_PULSE_RESPONDER_SVA_EN
    a_req_pulse : assert property (@(posedge clk) disable iff (rst) req |=> !req)
        else $error("req held high on consecutive edges");
    a_ack_pulse : assert property (@(posedge clk) disable iff (rst) ack |=> !ack)
        else $error("ack high on consecutive cycles");
`else
`endif

endmodule
